// File: rtl/tile_scheduler.sv
// Falling-tile rhythm game scheduler: owns the board, scoring, speed-up
// and the IDLE/PLAY/OVER game flow. Every output comes straight from a flop.
module tile_scheduler #(
  parameter int DEPTH        = 8,
  parameter int PERIOD_INIT  = 12,
  parameter int PERIOD_MIN   = 3,
  parameter int SPEEDUP_HITS = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               start,
  input  logic [3:0]         press,
  input  logic [3:0]         rand_tiles,
  output logic [4*DEPTH-1:0] board,
  output logic [7:0]         score,
  output logic               playing,
  output logic               game_over,
  output logic [3:0]         period
);

  localparam int HW = $clog2(SPEEDUP_HITS + 1);

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    OVER
  } state_t;

  state_t             state, state_nxt;
  logic [3:0]         tick_cnt, tick_cnt_nxt;
  logic [HW-1:0]      hit_cnt, hit_cnt_nxt;
  logic [4*DEPTH-1:0] board_nxt;
  logic [7:0]         score_nxt;
  logic [3:0]         period_nxt;
  logic               playing_nxt;
  logic               game_over_nxt;

  logic               target_found;
  logic [3:0]         target_row;
  logic [DEPTH-1:0]   target_sel;
  logic               press_one_hot;
  logic               hit;
  logic               press_fault;
  logic               advance;
  logic               miss_fault;
  logic               fault;
  logic [4*DEPTH-1:0] cleared;
  logic [3:0]         top_rot;
  logic [3:0]         spawn;

  // Find the lowest non-empty row: that is the only row a press may hit.
  always_comb begin
    target_found = 1'b0;
    target_row   = 4'b0000;
    target_sel   = '0;
    for (int r = 0; r < DEPTH; r++) begin
      if (!target_found && board[4*r +: 4] != 4'b0000) begin
        target_found  = 1'b1;
        target_row    = board[4*r +: 4];
        target_sel[r] = 1'b1;
      end
    end
  end

  assign press_one_hot = (press != 4'b0000) && ((press & (press - 4'd1)) == 4'b0000);
  assign hit           = (state == PLAY) && target_found && press_one_hot && (press == target_row);
  assign press_fault   = (state == PLAY) && target_found && (press != 4'b0000) && !hit;

  // Greater-or-equal keeps the board moving if a speed-up shrinks the
  // period while the counter already sits at the old last value.
  assign advance = (state == PLAY) && tick && (tick_cnt >= period - 4'd1);

  // Board after the hit clear; the advance (if any) acts on this view.
  always_comb begin
    cleared = board;
    for (int r = 0; r < DEPTH; r++) begin
      if (hit && target_sel[r]) begin
        cleared[4*r +: 4] = 4'b0000;
      end
    end
  end

  assign miss_fault = advance && (cleared[3:0] != 4'b0000);
  assign fault      = press_fault || miss_fault;

  // Spawn row: lowest random bit, else rotate the old top row, else lane 0.
  assign top_rot = {cleared[4*DEPTH-2 -: 3], cleared[4*DEPTH-1]};
  always_comb begin
    if (rand_tiles != 4'b0000) begin
      spawn = rand_tiles & (~rand_tiles + 4'd1);
    end else if (top_rot != 4'b0000) begin
      spawn = top_rot;
    end else begin
      spawn = 4'b0001;
    end
  end

  // Next-state and next-register values for the whole game.
  always_comb begin
    state_nxt    = state;
    board_nxt    = board;
    score_nxt    = score;
    period_nxt   = period;
    tick_cnt_nxt = tick_cnt;
    hit_cnt_nxt  = hit_cnt;
    case (state)
      IDLE, OVER: begin
        if (start) begin
          state_nxt    = PLAY;
          board_nxt    = '0;
          score_nxt    = 8'd0;
          period_nxt   = 4'(PERIOD_INIT);
          tick_cnt_nxt = 4'd0;
          hit_cnt_nxt  = '0;
        end
      end
      PLAY: begin
        if (fault) begin
          state_nxt = OVER;
        end else begin
          board_nxt = advance ? {spawn, cleared[4*DEPTH-1:4]} : cleared;
          if (hit) begin
            score_nxt = (score == 8'hFF) ? score : score + 8'd1;
            if (hit_cnt == HW'(SPEEDUP_HITS - 1)) begin
              hit_cnt_nxt = '0;
              period_nxt  = (period > 4'(PERIOD_MIN)) ? period - 4'd1 : period;
            end else begin
              hit_cnt_nxt = hit_cnt + HW'(1);
            end
          end
          if (tick) begin
            tick_cnt_nxt = advance ? 4'd0 : tick_cnt + 4'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    playing_nxt   = (state_nxt == PLAY);
    game_over_nxt = (state_nxt == OVER);
  end

  // State and output registers; reset abandons everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      board     <= '0;
      score     <= 8'd0;
      period    <= 4'(PERIOD_INIT);
      tick_cnt  <= 4'd0;
      hit_cnt   <= '0;
      playing   <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state     <= state_nxt;
      board     <= board_nxt;
      score     <= score_nxt;
      period    <= period_nxt;
      tick_cnt  <= tick_cnt_nxt;
      hit_cnt   <= hit_cnt_nxt;
      playing   <= playing_nxt;
      game_over <= game_over_nxt;
    end
  end

endmodule

// File: tb/tb_tile_scheduler.sv
// Self-checking bench for tile_scheduler: a row-array game model is
// compared on every cycle, plus hand-computed board/score snapshots.
module tb_tile_scheduler;

  localparam int DEPTH        = 8;
  localparam int PERIOD_INIT  = 12;
  localparam int PERIOD_MIN   = 3;
  localparam int SPEEDUP_HITS = 16;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               tick = 1'b0;
  logic               start = 1'b0;
  logic [3:0]         press = 4'b0000;
  logic [3:0]         rand_tiles = 4'b0000;
  logic [4*DEPTH-1:0] board;
  logic [7:0]         score;
  logic               playing;
  logic               game_over;
  logic [3:0]         period;

  int errors = 0;
  int checks = 0;
  bit check_en = 1'b0;

  // Game model: plain integer rows, row 0 is the hit line.
  int m_row[DEPTH];
  int m_score = 0;
  int m_period = PERIOD_INIT;
  int m_ticks = 0;
  int m_hits = 0;
  int m_hit_total = 0;
  bit m_playing = 1'b0;
  bit m_over = 1'b0;

  always #5 clk = ~clk;

  tile_scheduler #(
    .DEPTH(DEPTH),
    .PERIOD_INIT(PERIOD_INIT),
    .PERIOD_MIN(PERIOD_MIN),
    .SPEEDUP_HITS(SPEEDUP_HITS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tick(tick),
    .start(start),
    .press(press),
    .rand_tiles(rand_tiles),
    .board(board),
    .score(score),
    .playing(playing),
    .game_over(game_over),
    .period(period)
  );

  function automatic logic [4*DEPTH-1:0] modelBoard();
    logic [4*DEPTH-1:0] v;
    v = '0;
    for (int r = 0; r < DEPTH; r++) v[4*r +: 4] = 4'(m_row[r]);
    return v;
  endfunction

  function automatic logic [3:0] modelTarget();
    for (int r = 0; r < DEPTH; r++) begin
      if (m_row[r] != 0) return 4'(m_row[r]);
    end
    return 4'b0000;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic t, input logic s, input logic [3:0] p, input logic [3:0] r);
    tick       = t;
    start      = s;
    press      = p;
    rand_tiles = r;
    @(posedge clk);
    #1;
  endtask

  // Keep ticking and pressing the model's target until n more hits land.
  task automatic autoPlay(input int n);
    int goal;
    int budget;
    int cyc;
    goal   = m_hit_total + n;
    budget = n * 20 + 50;
    cyc    = 0;
    while (m_hit_total < goal && cyc < budget) begin
      applyStimulus(1'b1, 1'b0, modelTarget(), 4'(cyc));
      cyc++;
    end
    checkOutput("autoplay_hits_reached", 64'(m_hit_total), 64'(goal));
    applyStimulus(1'b0, 1'b0, 4'b0000, 4'b0000);
  endtask

  // Model update on each rising edge from the same sampled inputs.
  always @(posedge clk) begin : model_step
    int tgt;
    int tmp[DEPTH];
    bit hit;
    bit flt;
    bit adv;
    int sp;
    int top;
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) m_row[r] = 0;
      m_score = 0; m_period = PERIOD_INIT; m_ticks = 0; m_hits = 0;
      m_playing = 1'b0; m_over = 1'b0;
    end else if (!m_playing) begin
      if (start) begin
        for (int r = 0; r < DEPTH; r++) m_row[r] = 0;
        m_score = 0; m_period = PERIOD_INIT; m_ticks = 0; m_hits = 0;
        m_playing = 1'b1; m_over = 1'b0;
      end
    end else begin
      tgt = -1;
      for (int r = 0; r < DEPTH; r++) if (tgt < 0 && m_row[r] != 0) tgt = r;
      hit = 1'b0;
      flt = 1'b0;
      if (press != 4'b0000 && tgt >= 0) begin
        if ($countones(press) == 1 && int'(press) == m_row[tgt]) hit = 1'b1;
        else flt = 1'b1;
      end
      adv = tick && (m_ticks >= m_period - 1);
      tmp = m_row;
      if (hit) tmp[tgt] = 0;
      if (adv && tmp[0] != 0) flt = 1'b1;
      if (flt) begin
        m_playing = 1'b0;
        m_over    = 1'b1;
      end else begin
        m_row = tmp;
        if (hit) begin
          m_hit_total++;
          if (m_score < 255) m_score++;
          m_hits++;
          if (m_hits == SPEEDUP_HITS) begin
            m_hits = 0;
            if (m_period > PERIOD_MIN) m_period--;
          end
        end
        if (tick) m_ticks = adv ? 0 : m_ticks + 1;
        if (adv) begin
          if (rand_tiles != 4'b0000) begin
            sp = 0;
            for (int b = 3; b >= 0; b--) if (rand_tiles[b]) sp = 1 << b;
          end else begin
            top = m_row[DEPTH-1];
            sp  = ((top * 2) % 16) + (top / 8);
            if (sp == 0) sp = 1;
          end
          for (int r = 0; r < DEPTH - 1; r++) m_row[r] = m_row[r+1];
          m_row[DEPTH-1] = sp;
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("cmp_board", 64'(board), 64'(modelBoard()));
      checkOutput("cmp_score", 64'(score), 64'(m_score));
      checkOutput("cmp_period", 64'(period), 64'(m_period));
      checkOutput("cmp_playing", 64'(playing), 64'(m_playing));
      checkOutput("cmp_game_over", 64'(game_over), 64'(m_over));
    end
  end

  // Directed scenario sequence with hand-computed snapshots.
  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 4'b0000, 4'b0000);
    check_en = 1'b1;
    applyStimulus(1'b1, 1'b1, 4'b0001, 4'b0001);
    checkOutput("reset_board", 64'(board), 64'h0);
    checkOutput("reset_score", 64'(score), 64'h0);
    checkOutput("reset_period", 64'(period), 64'd12);
    checkOutput("reset_playing", 64'(playing), 64'h0);
    checkOutput("reset_game_over", 64'(game_over), 64'h0);

    rst = 1'b0;
    repeat (3) applyStimulus(1'b1, 1'b0, 4'b0001, 4'b0110);
    checkOutput("idle_ignores_playing", 64'(playing), 64'h0);
    checkOutput("idle_ignores_board", 64'(board), 64'h0);

    applyStimulus(1'b0, 1'b1, 4'b0000, 4'b0000);
    checkOutput("start_playing", 64'(playing), 64'h1);

    repeat (12) applyStimulus(1'b1, 1'b0, 4'b0000, 4'b0110);
    checkOutput("first_spawn_top", 64'(board[4*DEPTH-1 -: 4]), 64'b0010);
    checkOutput("first_spawn_playing", 64'(playing), 64'h1);
    checkOutput("first_spawn_score", 64'(score), 64'h0);

    repeat (84) applyStimulus(1'b1, 1'b0, 4'b0000, 4'b0000);
    checkOutput("full_board_rotate", 64'(board), 64'h18421842);
    applyStimulus(1'b0, 1'b0, 4'b0010, 4'b0000);
    checkOutput("row0_hit_board", 64'(board), 64'h18421840);
    checkOutput("row0_hit_score", 64'(score), 64'd1);
    checkOutput("row0_hit_no_over", 64'(game_over), 64'h0);
    applyStimulus(1'b0, 1'b0, 4'b0001, 4'b0000);
    checkOutput("wrong_lane_over", 64'(game_over), 64'h1);
    checkOutput("wrong_lane_frozen", 64'(board), 64'h18421840);
    repeat (3) applyStimulus(1'b1, 1'b0, 4'b0001, 4'b0001);
    checkOutput("over_holds_board", 64'(board), 64'h18421840);
    checkOutput("over_holds_score", 64'(score), 64'd1);

    applyStimulus(1'b0, 1'b1, 4'b0000, 4'b0000);
    checkOutput("restart_score", 64'(score), 64'h0);
    checkOutput("restart_period", 64'(period), 64'd12);
    checkOutput("restart_board", 64'(board), 64'h0);
    repeat (12) applyStimulus(1'b1, 1'b0, 4'b0000, 4'b1000);
    repeat (36) applyStimulus(1'b1, 1'b0, 4'b0000, 4'b0000);
    checkOutput("rotate_wrap_board", 64'(board), 64'h42180000);
    applyStimulus(1'b0, 1'b0, 4'b0011, 4'b0000);
    checkOutput("two_bit_press_over", 64'(game_over), 64'h1);
    checkOutput("two_bit_press_frozen", 64'(board), 64'h42180000);

    applyStimulus(1'b0, 1'b1, 4'b0000, 4'b0000);
    repeat (12) applyStimulus(1'b1, 1'b0, 4'b0000, 4'b0001);
    repeat (84) applyStimulus(1'b1, 1'b0, 4'b0000, 4'b0000);
    checkOutput("miss_setup_board", 64'(board), 64'h84218421);
    repeat (12) applyStimulus(1'b1, 1'b0, 4'b0000, 4'b0000);
    checkOutput("miss_over", 64'(game_over), 64'h1);
    checkOutput("miss_frozen", 64'(board), 64'h84218421);

    applyStimulus(1'b0, 1'b1, 4'b0000, 4'b0000);
    repeat (12) applyStimulus(1'b1, 1'b0, 4'b0000, 4'b0001);
    repeat (95) applyStimulus(1'b1, 1'b0, 4'b0000, 4'b0000);
    applyStimulus(1'b1, 1'b0, 4'b0001, 4'b0000);
    checkOutput("save_in_advance_board", 64'(board), 64'h18421842);
    checkOutput("save_in_advance_score", 64'(score), 64'd1);
    checkOutput("save_in_advance_playing", 64'(playing), 64'h1);

    autoPlay(4);
    checkOutput("pre_reset_score", 64'(score), 64'd5);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 4'b0000, 4'b0000);
    rst = 1'b0;
    checkOutput("midgame_reset_score", 64'(score), 64'h0);
    checkOutput("midgame_reset_board", 64'(board), 64'h0);
    checkOutput("midgame_reset_playing", 64'(playing), 64'h0);

    applyStimulus(1'b0, 1'b1, 4'b0000, 4'b0000);
    autoPlay(16);
    checkOutput("speedup_16_period", 64'(period), 64'd11);
    checkOutput("speedup_16_score", 64'(score), 64'd16);
    autoPlay(128);
    checkOutput("speedup_floor_period", 64'(period), 64'd3);
    autoPlay(16);
    checkOutput("speedup_floor_hold", 64'(period), 64'd3);
    autoPlay(95);
    checkOutput("score_255", 64'(score), 64'd255);
    autoPlay(1);
    checkOutput("score_saturate", 64'(score), 64'd255);
    checkOutput("score_saturate_playing", 64'(playing), 64'h1);

    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
